// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two WB requesters (ALU = port 0, load = port 1)
// and the arbiter, plus the registered regfile write port and pending-write mask.
interface regfile_wb_arbiter_if #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 8
);
  logic            wr_valid0;
  logic            wr_ready0;
  logic [AW-1:0]   wr_addr0;
  logic [DW-1:0]   wr_data0;
  logic            wr_valid1;
  logic            wr_ready1;
  logic [AW-1:0]   wr_addr1;
  logic [DW-1:0]   wr_data1;
  logic            load;
  logic [AW-1:0]   wsel;
  logic [DW-1:0]   d;
  logic [NREG-1:0] busy;

  modport master (
    output wr_valid0, wr_addr0, wr_data0,
    output wr_valid1, wr_addr1, wr_data1,
    input  wr_ready0, wr_ready1,
    input  load, wsel, d, busy
  );

  modport slave (
    input  wr_valid0, wr_addr0, wr_data0,
    input  wr_valid1, wr_addr1, wr_data1,
    output wr_ready0, wr_ready1,
    output load, wsel, d, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load writeback: one holding buffer per
// port, round-robin between buffers, oldest-first when both target the same register.
module regfile_wb_arbiter #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  regfile_wb_arbiter_if.slave bus
);

  logic          bufValid0_q, bufValid0_d;
  logic [AW-1:0] bufAddr0_q,  bufAddr0_d;
  logic [DW-1:0] bufData0_q,  bufData0_d;
  logic          bufValid1_q, bufValid1_d;
  logic [AW-1:0] bufAddr1_q,  bufAddr1_d;
  logic [DW-1:0] bufData1_q,  bufData1_d;
  logic          rrPtr_q,     rrPtr_d;
  logic          old0_q,      old0_d;
  logic          load_q,      load_d;
  logic [AW-1:0] wsel_q,      wsel_d;
  logic [DW-1:0] d_q,         d_d;

  logic            gnt0, gnt1;
  logic            ready0, ready1;
  logic            xfer0, xfer1;
  logic            bothValid;
  logic [NREG-1:0] busyVec;

  // Same-register pairs resolve by age so writes to one register never reorder;
  // otherwise the round-robin pointer picks, keeping each port's wait to one grant.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    bothValid = bufValid0_q & bufValid1_q;
    if (bothValid) begin
      if (bufAddr0_q == bufAddr1_q) begin
        gnt0 = old0_q;
      end else begin
        gnt0 = ~rrPtr_q;
      end
      gnt1 = ~gnt0;
    end else begin
      gnt0 = bufValid0_q;
      gnt1 = bufValid1_q;
    end
    ready0 = ~bufValid0_q | gnt0;
    ready1 = ~bufValid1_q | gnt1;
    xfer0  = bus.wr_valid0 & ready0;
    xfer1  = bus.wr_valid1 & ready1;
  end

  always_comb begin
    bufValid0_d = xfer0 | (bufValid0_q & ~gnt0);
    bufAddr0_d  = bufAddr0_q;
    bufData0_d  = bufData0_q;
    bufValid1_d = xfer1 | (bufValid1_q & ~gnt1);
    bufAddr1_d  = bufAddr1_q;
    bufData1_d  = bufData1_q;
    rrPtr_d     = rrPtr_q;
    old0_d      = old0_q;
    load_d      = gnt0 | gnt1;
    wsel_d      = wsel_q;
    d_d         = d_q;

    if (xfer0) begin
      bufAddr0_d = bus.wr_addr0;
      bufData0_d = bus.wr_data0;
    end
    if (xfer1) begin
      bufAddr1_d = bus.wr_addr1;
      bufData1_d = bus.wr_data1;
    end

    if (bothValid) begin
      rrPtr_d = gnt0;
    end

    // An entry that stays put while the other buffer refills becomes the older one.
    if (xfer0 && xfer1) begin
      old0_d = 1'b1;
    end else if (xfer0 && bufValid1_q && !gnt1) begin
      old0_d = 1'b0;
    end else if (xfer1 && bufValid0_q && !gnt0) begin
      old0_d = 1'b1;
    end

    if (gnt0) begin
      wsel_d = bufAddr0_q;
      d_d    = bufData0_q;
    end else if (gnt1) begin
      wsel_d = bufAddr1_q;
      d_d    = bufData1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bufValid0_q <= 1'b0;
      bufAddr0_q  <= '0;
      bufData0_q  <= '0;
      bufValid1_q <= 1'b0;
      bufAddr1_q  <= '0;
      bufData1_q  <= '0;
      rrPtr_q     <= 1'b0;
      old0_q      <= 1'b0;
      load_q      <= 1'b0;
      wsel_q      <= '0;
      d_q         <= '0;
    end else begin
      bufValid0_q <= bufValid0_d;
      bufAddr0_q  <= bufAddr0_d;
      bufData0_q  <= bufData0_d;
      bufValid1_q <= bufValid1_d;
      bufAddr1_q  <= bufAddr1_d;
      bufData1_q  <= bufData1_d;
      rrPtr_q     <= rrPtr_d;
      old0_q      <= old0_d;
      load_q      <= load_d;
      wsel_q      <= wsel_d;
      d_q         <= d_d;
    end
  end

  // A register stays busy until the cycle after its value is captured by the regfile.
  always_comb begin
    busyVec = '0;
    if (bufValid0_q) begin
      busyVec[bufAddr0_q] = 1'b1;
    end
    if (bufValid1_q) begin
      busyVec[bufAddr1_q] = 1'b1;
    end
    if (load_q) begin
      busyVec[wsel_q] = 1'b1;
    end
  end

  assign bus.wr_ready0 = ready0;
  assign bus.wr_ready1 = ready1;
  assign bus.load      = load_q;
  assign bus.wsel      = wsel_q;
  assign bus.d         = d_q;
  assign bus.busy      = busyVec;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, scored against
// a model that tracks accepted-but-unwritten writes and the resulting register contents.
module tb_regfile_wb_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 8;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            seq;
    bit            onOut;
    int            passes;
  } item_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW), .NREG(NREG)) bus ();

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  item_t         pending[$];
  logic [DW-1:0] shadow   [NREG];
  logic [DW-1:0] expFinal [NREG];
  int            assertCount = 0;
  int            failCount   = 0;
  int            seqNext     = 0;
  bit            granted;
  int            grantPort;
  logic [DW-1:0] lastAcc1Data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.wr_valid0 = v0;
    bus.wr_addr0  = a0;
    bus.wr_data0  = d0;
    bus.wr_valid1 = v1;
    bus.wr_addr1  = a1;
    bus.wr_data1  = d1;
  endtask

  function automatic int countBuffered(input int port);
    int n = 0;
    foreach (pending[i]) if (pending[i].port == port && !pending[i].onOut) n++;
    return n;
  endfunction

  // One clock: decide acceptance from the handshake, retire the write the regfile just
  // captured, identify the newly granted write, then record newly accepted writes.
  task automatic tick();
    int            nb0, nb1, idx;
    bit            x0, x1, anyBuf, found, orderViol;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [NREG-1:0] eb;
    item_t         it;

    nb0 = countBuffered(0);
    nb1 = countBuffered(1);
    if (nb0 + nb1 <= 1) begin
      checkOutput("ready0", 32'(bus.wr_ready0), 32'd1);
      checkOutput("ready1", 32'(bus.wr_ready1), 32'd1);
    end else begin
      checkOutput("readyOneHot", 32'(bus.wr_ready0 ^ bus.wr_ready1), 32'd1);
    end
    x0 = bus.wr_valid0 && bus.wr_ready0;
    x1 = bus.wr_valid1 && bus.wr_ready1;
    a0 = bus.wr_addr0;  d0 = bus.wr_data0;
    a1 = bus.wr_addr1;  d1 = bus.wr_data1;
    anyBuf = (nb0 + nb1) > 0;

    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < pending.size(); i++) begin
      if (pending[i].onOut) begin
        shadow[pending[i].addr] = pending[i].data;
        pending.delete(i);
        break;
      end
    end

    granted = 1'b0;
    checkOutput("load", 32'(bus.load), 32'(anyBuf));
    if (bus.load === 1'b1) begin
      found = 1'b0;
      idx   = -1;
      for (int i = 0; i < pending.size(); i++) begin
        if (!pending[i].onOut && pending[i].addr == bus.wsel && pending[i].data == bus.d &&
            (!found || pending[i].seq < pending[idx].seq)) begin
          found = 1'b1;
          idx   = i;
        end
      end
      checkOutput("grantMatch", 32'(found), 32'd1);
      if (found) begin
        orderViol = 1'b0;
        for (int i = 0; i < pending.size(); i++) begin
          if (!pending[i].onOut && i != idx && pending[i].addr == pending[idx].addr &&
              pending[i].seq < pending[idx].seq) orderViol = 1'b1;
        end
        checkOutput("sameRegOrder", 32'(orderViol), 32'd0);
        pending[idx].onOut = 1'b1;
        granted   = 1'b1;
        grantPort = pending[idx].port;
        for (int i = 0; i < pending.size(); i++) begin
          if (!pending[i].onOut) begin
            pending[i].passes++;
            checkOutput("fairness", 32'(pending[i].passes <= 1), 32'd1);
          end
        end
      end
    end

    if (x0) begin
      it = '{port: 0, addr: a0, data: d0, seq: seqNext, onOut: 1'b0, passes: 0};
      pending.push_back(it);
      seqNext++;
      expFinal[a0] = d0;
    end
    if (x1) begin
      it = '{port: 1, addr: a1, data: d1, seq: seqNext, onOut: 1'b0, passes: 0};
      pending.push_back(it);
      seqNext++;
      expFinal[a1] = d1;
      lastAcc1Data = d1;
    end
    checkOutput("portCap", 32'(countBuffered(0) <= 1 && countBuffered(1) <= 1), 32'd1);

    eb = '0;
    foreach (pending[i]) eb[pending[i].addr] = 1'b1;
    checkOutput("busy", 32'(bus.busy), 32'(eb));
  endtask

  task automatic drain();
    applyStimulus(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 8 && pending.size() > 0; i++) tick();
    checkOutput("drained", 32'(pending.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prevPort;
    bit v0, v1;
    for (int r = 0; r < NREG; r++) begin
      shadow[r]   = '0;
      expFinal[r] = '0;
    end

    // Reset held with live traffic: nothing may leave, both ports read as ready.
    applyStimulus(1, 3'd4, 16'h1234, 1, 3'd6, 16'h5678);
    #1 rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstLoad",   32'(bus.load),      32'd0);
      checkOutput("rstBusy",   32'(bus.busy),      32'd0);
      checkOutput("rstReady0", 32'(bus.wr_ready0), 32'd1);
      checkOutput("rstReady1", 32'(bus.wr_ready1), 32'd1);
      checkOutput("rstWsel",   32'(bus.wsel),      32'd0);
      checkOutput("rstD",      32'(bus.d),         32'd0);
    end
    applyStimulus(0, '0, '0, 0, '0, '0);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] single write r3=BEEF");
    applyStimulus(1, 3'd3, 16'hBEEF, 0, '0, '0);
    tick();
    checkOutput("singleBusyBuf", 32'(bus.busy[3]), 32'd1);
    applyStimulus(0, '0, '0, 0, '0, '0);
    tick();
    checkOutput("singleLoad", 32'(bus.load), 32'd1);
    checkOutput("singleWsel", 32'(bus.wsel), 32'd3);
    checkOutput("singleD",    32'(bus.d),    32'hBEEF);
    checkOutput("singleBusyOut", 32'(bus.busy[3]), 32'd1);
    tick();
    checkOutput("singleBusyClear", 32'(bus.busy[3]), 32'd0);
    drain();

    $display("[TB] contention r1/r2");
    prevPort = -1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 3'd1, 16'($urandom), 1, 3'd2, 16'($urandom));
      tick();
      if (granted) begin
        if (prevPort >= 0) checkOutput("alternate", 32'(grantPort != prevPort), 32'd1);
        prevPort = grantPort;
      end
    end
    drain();

    $display("[TB] same-register ordering");
    applyStimulus(1, 3'd6, 16'hAAAA, 1, 3'd5, 16'h1111);
    tick();
    applyStimulus(1, 3'd5, 16'h2222, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      v0 = bus.wr_ready0;
      tick();
      if (v0) break;
    end
    drain();
    checkOutput("orderR5", 32'(shadow[5]), 32'h2222);
    applyStimulus(1, 3'd5, 16'h3333, 1, 3'd5, 16'h4444);
    tick();
    drain();
    checkOutput("tieR5", 32'(shadow[5]), 32'h4444);

    $display("[TB] back-pressure with changing data");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 3'd0, 16'($urandom), 1, 3'd4, 16'($urandom));
      tick();
    end
    drain();
    checkOutput("backPressR4", 32'(shadow[4]), 32'(lastAcc1Data));

    $display("[TB] mid-operation reset");
    applyStimulus(1, 3'd1, 16'h5A5A, 1, 3'd2, 16'hA5A5);
    tick();
    applyStimulus(0, '0, '0, 0, '0, '0);
    rst_ni = 1'b0;
    #1;
    checkOutput("midRstLoad",   32'(bus.load),      32'd0);
    checkOutput("midRstBusy",   32'(bus.busy),      32'd0);
    checkOutput("midRstReady0", 32'(bus.wr_ready0), 32'd1);
    checkOutput("midRstReady1", 32'(bus.wr_ready1), 32'd1);
    #1 rst_ni = 1'b1;
    pending.delete();
    for (int r = 0; r < NREG; r++) expFinal[r] = shadow[r];
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      applyStimulus(v0, 3'($urandom_range(0, 3)), 16'($urandom),
                    v1, 3'($urandom_range(0, 7)), 16'($urandom));
      tick();
    end
    drain();

    for (int r = 0; r < NREG; r++) begin
      checkOutput($sformatf("finalR%0d", r), 32'(shadow[r]), 32'(expFinal[r]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
